// File: rtl/mac_accumulator.sv
// mac_accumulator
//    Sums a programmed number of 64-bit signed products from the 32x32 signed
//    multiplier into a guard-bit accumulator. The sum is then rounded
//    (half-up) and saturated to a signed 32-bit result in Q(FRAC_SHIFT).
//    Typical uses are dot products and filter-tap reduction.
//
// Ports
//    clk         in   system clock, rising edge
//    rst         in   asynchronous active-high reset
//    start       in   begin a block; sampled only in IDLE
//    len         in   block length in products; latched on start (0 = ignored)
//    prod        in   64-bit signed product
//    prod_valid  in   prod is valid this cycle
//    prod_ready  out  block accepts prod this cycle (ACCUM only)
//    acc_out     out  rounded, saturated signed 32-bit result
//    acc_valid   out  acc_out is valid (HOLD)
//    acc_ready   in   downstream accepts acc_out
//    sat         out  acc_out was clipped; qualified by acc_valid
//    busy        out  block is not in IDLE
module mac_accumulator #(
   parameter int LEN_W      = 8,
   parameter int ACC_W      = 64 + LEN_W,
   parameter int FRAC_SHIFT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [63:0]      prod,
   input  logic             prod_valid,
   output logic             prod_ready,
   output logic [31:0]      acc_out,
   output logic             acc_valid,
   input  logic             acc_ready,
   output logic             sat,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      ROUND = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic signed [ACC_W-1:0] HALF    = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
   localparam logic signed [ACC_W-1:0] MAX_POS = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_NEG = {{(ACC_W-31){1'b1}}, {31{1'b0}}};

   state_t                  state;
   state_t                  state_next;
   logic signed [ACC_W-1:0] acc;
   logic [LEN_W-1:0]        remaining;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] acc_biased;
   logic signed [ACC_W-1:0] rounded;
   logic [31:0]             out_next;
   logic                    sat_next;

   assign prod_ext = {{(ACC_W-64){prod[63]}}, prod};

   // Round half-up toward +inf: add half an LSB, then arithmetic shift.
   // The guard bits leave headroom for the bias even on a full-scale sum.
   assign acc_biased = acc + HALF;
   assign rounded    = acc_biased >>> FRAC_SHIFT;

   always_comb begin
      out_next = rounded[31:0];
      sat_next = 1'b0;
      if (rounded > MAX_POS) begin
         out_next = 32'h7FFF_FFFF;
         sat_next = 1'b1;
      end else if (rounded < MIN_NEG) begin
         out_next = 32'h8000_0000;
         sat_next = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and state-decoded handshake outputs
   always_comb begin
      state_next = state;
      prod_ready = 1'b0;
      acc_valid  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start && (len != '0)) begin
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            prod_ready = 1'b1;
            if (prod_valid && (remaining == LEN_W'(1))) begin
               state_next = ROUND;
            end
         end
         ROUND: begin
            state_next = HOLD;
         end
         HOLD: begin
            acc_valid = 1'b1;
            if (acc_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: accumulator, product countdown and result registers.
   // acc_out/sat are loaded only in ROUND, so they stay stable through HOLD
   // and keep their value after the output handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         remaining <= '0;
         acc_out   <= '0;
         sat       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && (len != '0)) begin
                  acc       <= '0;
                  remaining <= len;
               end
            end
            ACCUM: begin
               if (prod_valid) begin
                  acc       <= acc + prod_ext;
                  remaining <= remaining - LEN_W'(1);
               end
            end
            ROUND: begin
               acc_out <= out_next;
               sat     <= sat_next;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_accumulator.sv
module tb_mac_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic [63:0] prod;
   logic        prod_valid;
   logic        prod_ready;
   logic [31:0] acc_out;
   logic        acc_valid;
   logic        acc_ready;
   logic        sat;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int hs_count = 0;

   // Scoreboard of expected {sat, acc_out}
   logic [32:0] exp_q[$];

   mac_accumulator #(
      .LEN_W(8),
      .ACC_W(72),
      .FRAC_SHIFT(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .len(len),
      .prod(prod),
      .prod_valid(prod_valid),
      .prod_ready(prod_ready),
      .acc_out(acc_out),
      .acc_valid(acc_valid),
      .acc_ready(acc_ready),
      .sat(sat),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (prod_valid && prod_ready) hs_count <= hs_count + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: round half-up, then clip to signed 32 bits.
   function automatic logic [32:0] model(input logic signed [71:0] s);
      logic signed [71:0] r;
      r = (s + 72'sd32768) >>> 16;
      if (r > 72'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
      if (r < -72'sd2147483648) return {1'b1, 32'h8000_0000};
      return {1'b0, r[31:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_block(input logic [7:0] l);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
   endtask

   // Present p and return just after the edge that accepts it.
   task automatic send_prod(input logic [63:0] p);
      bit hs;
      int n;
      prod       = p;
      prod_valid = 1'b1;
      n = 0;
      hs = 1'b0;
      while (!hs && n < 50) begin
         hs = prod_ready;
         tick();
         n++;
      end
      if (!hs) begin
         checks++;
         errors++;
         $display("FAIL prod_handshake: prod_ready never seen within %0d cycles", n);
      end
   endtask

   task automatic wait_valid(output bit ok);
      int n;
      n = 0;
      while (!acc_valid && n < 400) begin
         tick();
         n++;
      end
      ok = acc_valid;
   endtask

   task automatic release_hold();
      acc_ready = 1'b1;
      tick();
      acc_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({acc_out, acc_valid, sat, busy, prod_ready} !== 36'h0) begin
         errors++;
         $display("FAIL reset_state: got out=%h v=%b sat=%b busy=%b rdy=%b, expected all 0",
                  acc_out, acc_valid, sat, busy, prod_ready);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_block();
      bit ok;
      logic [32:0] e;
      start_block(8'd4);
      send_prod(64'h1_0000);
      send_prod(64'h1_0000);
      prod_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || prod_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_block_busy: got busy=%b rdy=%b, expected 1 1", busy, prod_ready);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({acc_out, acc_valid, sat, busy, prod_ready} !== 36'h0) begin
         errors++;
         $display("FAIL async_reset: got out=%h v=%b sat=%b busy=%b rdy=%b, expected all 0",
                  acc_out, acc_valid, sat, busy, prod_ready);
      end
      #1 rst = 1'b0;
      tick();
      start_block(8'd1);
      exp_q.push_back({1'b0, 32'h0000_0001});
      send_prod(64'h1_0000);
      prod_valid = 1'b0;
      wait_valid(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL after_reset_valid: acc_valid=%b, expected 1", acc_valid);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if ({sat, acc_out} !== e) begin
            errors++;
            $display("FAIL after_reset_result: got %h, expected %h", {sat, acc_out}, e);
         end
      end
      release_hold();
   endtask

   task automatic test_rounding_latency();
      bit ok;
      logic [32:0] e;
      start_block(8'd3);
      exp_q.push_back({1'b0, 32'h0000_0005});
      send_prod(64'h3_0000);
      send_prod(64'hFFFF_FFFF_FFFF_0000);
      send_prod(64'h2_8000);
      prod_valid = 1'b0;
      // One edge after the final handshake: in ROUND, result not yet valid.
      checks++;
      if (acc_valid !== 1'b0 || prod_ready !== 1'b0) begin
         errors++;
         $display("FAIL latency_round: got v=%b rdy=%b, expected 0 0", acc_valid, prod_ready);
      end
      tick();
      checks++;
      if (acc_valid !== 1'b1) begin
         errors++;
         $display("FAIL latency_hold: acc_valid=%b, expected 1", acc_valid);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if ({sat, acc_out} !== e) begin
            errors++;
            $display("FAIL round_half_up: got %h, expected %h", {sat, acc_out}, e);
         end
      end
      release_hold();

      start_block(8'd1);
      exp_q.push_back({1'b0, 32'hFFFF_FFFF});
      send_prod(64'hFFFF_FFFF_FFFE_8000);
      prod_valid = 1'b0;
      wait_valid(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL neg_round_valid: acc_valid=%b, expected 1", acc_valid);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if ({sat, acc_out} !== e) begin
            errors++;
            $display("FAIL neg_round: got %h, expected %h", {sat, acc_out}, e);
         end
      end
      release_hold();
   endtask

   task automatic test_saturation();
      bit ok;
      logic [32:0] e;
      start_block(8'd2);
      exp_q.push_back({1'b1, 32'h7FFF_FFFF});
      send_prod(64'h0000_7FFF_FFFF_0000);
      send_prod(64'h0000_7FFF_FFFF_0000);
      prod_valid = 1'b0;
      wait_valid(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL sat_pos_valid: acc_valid=%b, expected 1", acc_valid);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if ({sat, acc_out} !== e) begin
            errors++;
            $display("FAIL sat_pos: got %h, expected %h", {sat, acc_out}, e);
         end
      end
      release_hold();

      start_block(8'd1);
      exp_q.push_back({1'b1, 32'h8000_0000});
      send_prod(64'h8000_0000_0000_0000);
      prod_valid = 1'b0;
      wait_valid(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL sat_neg_valid: acc_valid=%b, expected 1", acc_valid);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if ({sat, acc_out} !== e) begin
            errors++;
            $display("FAIL sat_neg: got %h, expected %h", {sat, acc_out}, e);
         end
      end
      release_hold();
   endtask

   task automatic test_input_gaps();
      bit ok;
      int base;
      logic [32:0] e;
      base = hs_count;
      start_block(8'd4);
      exp_q.push_back({1'b0, 32'h0000_0004});
      for (int i = 0; i < 4; i++) begin
         send_prod(64'h1_0000);
         if (i < 3) begin
            prod_valid = 1'b0;
            tick();
         end
      end
      // prod_valid stays high through ROUND and HOLD
      tick();
      tick();
      checks++;
      if (prod_ready !== 1'b0 || (hs_count - base) !== 4) begin
         errors++;
         $display("FAIL gap_handshakes: got rdy=%b count=%0d, expected 0 4",
                  prod_ready, hs_count - base);
      end
      wait_valid(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL gap_valid: acc_valid=%b, expected 1", acc_valid);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if ({sat, acc_out} !== e) begin
            errors++;
            $display("FAIL gap_result: got %h, expected %h", {sat, acc_out}, e);
         end
      end
      prod_valid = 1'b0;
      release_hold();
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [32:0] e;
      start_block(8'd1);
      exp_q.push_back({1'b0, 32'h0000_0002});
      send_prod(64'h2_0000);
      prod_valid = 1'b0;
      wait_valid(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_valid: acc_valid=%b, expected 1", acc_valid);
      end else begin
         e = exp_q.pop_front();
         for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 8'd3;
            tick();
            start = 1'b0;
            checks++;
            if ({acc_valid, busy, sat, acc_out} !== {2'b11, e}) begin
               errors++;
               $display("FAIL bp_hold_%0d: got v=%b busy=%b res=%h, expected 1 1 %h",
                        i, acc_valid, busy, {sat, acc_out}, e);
            end
         end
      end
      release_hold();
      checks++;
      if (acc_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: got v=%b busy=%b, expected 0 0", acc_valid, busy);
      end
      start_block(8'd1);
      checks++;
      if (busy !== 1'b1 || prod_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_restart: got busy=%b rdy=%b, expected 1 1", busy, prod_ready);
      end
      exp_q.push_back({1'b0, 32'h0000_0000});
      send_prod(64'h0);
      prod_valid = 1'b0;
      wait_valid(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_restart_valid: acc_valid=%b, expected 1", acc_valid);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if ({sat, acc_out} !== e) begin
            errors++;
            $display("FAIL bp_restart_result: got %h, expected %h", {sat, acc_out}, e);
         end
      end
      release_hold();
   endtask

   task automatic test_boundaries();
      bit ok;
      logic [32:0] e;
      start_block(8'd0);
      tick();
      checks++;
      if (busy !== 1'b0 || prod_ready !== 1'b0) begin
         errors++;
         $display("FAIL len_zero: got busy=%b rdy=%b, expected 0 0", busy, prod_ready);
      end
      start_block(8'd255);
      exp_q.push_back({1'b1, 32'h7FFF_FFFF});
      for (int i = 0; i < 255; i++) send_prod(64'h7FFF_FFFF_FFFF_FFFF);
      prod_valid = 1'b0;
      wait_valid(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL full_len_valid: acc_valid=%b, expected 1", acc_valid);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if ({sat, acc_out} !== e) begin
            errors++;
            $display("FAIL full_len_result: got %h, expected %h", {sat, acc_out}, e);
         end
      end
      release_hold();
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [32:0] e;
      logic [63:0] p;
      logic [31:0] r;
      logic signed [71:0] s;
      int l;
      acc_ready = 1'b1;
      for (int b = 0; b < 6; b++) begin
         l = $urandom_range(4, 1);
         s = '0;
         start_block(8'(l));
         for (int i = 0; i < l; i++) begin
            r = $urandom;
            if ($urandom_range(1, 0) == 0) p = {{32{r[31]}}, r};
            else p = {$urandom, r};
            s = s + {{8{p[63]}}, p};
            send_prod(p);
         end
         exp_q.push_back(model(s));
         prod_valid = 1'b0;
         wait_valid(ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL b2b_valid_%0d: acc_valid=%b, expected 1", b, acc_valid);
         end else begin
            e = exp_q.pop_front();
            checks++;
            if ({sat, acc_out} !== e) begin
               errors++;
               $display("FAIL b2b_result_%0d: got %h, expected %h", b, {sat, acc_out}, e);
            end
         end
         tick();
      end
      acc_ready = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      len        = '0;
      prod       = '0;
      prod_valid = 1'b0;
      acc_ready  = 1'b0;
      test_reset();
      test_reset_mid_block();
      test_rounding_latency();
      test_saturation();
      test_input_gaps();
      test_backpressure();
      test_boundaries();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
